// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment display blocks.
// Segment vectors are ordered a..g, active-high.
package seg7_pkg;
  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 32;

  localparam logic [1:7] SEG_BLANK = 7'b0000000;
  localparam logic [1:7] SEG_DASH  = 7'b0000001;

  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned i);
    logic [MAX_DIGITS-1:0] v;
    v = MAX_DIGITS'(1) << i;
    return v;
  endfunction
endpackage

// File: rtl/seg7.sv
// Combinational BCD to 7-segment decoder, segments a..g active-high.
// Codes above 9 decode to all-off; the caller decides how to present them.
module seg7
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [1:7]       leds
);

  always_comb begin
    leds = SEG_BLANK;
    case (bcd)
      4'd0:    leds = 7'b1111110;
      4'd1:    leds = 7'b0110000;
      4'd2:    leds = 7'b1101101;
      4'd3:    leds = 7'b1111001;
      4'd4:    leds = 7'b0110011;
      4'd5:    leds = 7'b1011011;
      4'd6:    leds = 7'b1011111;
      4'd7:    leds = 7'b1110000;
      4'd8:    leds = 7'b1111111;
      4'd9:    leds = 7'b1111011;
      default: leds = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a multi-digit common-cathode 7-segment display.
// New data is handed to the display only at frame boundaries so a frame never tears.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
  output logic [1:7]                  leds,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_done,
  output logic                        load_ack
);

  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int DATA_W  = BCD_W * NUM_DIGITS;

  logic [PRESC_W-1:0]    presc_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [DATA_W-1:0]     shadow_reg;
  logic [DATA_W-1:0]     pend_data_reg;
  logic                  pend_reg;

  logic                  tick;
  logic                  boundary;
  logic [BCD_W-1:0]      digit [NUM_DIGITS];
  logic [BCD_W-1:0]      cur_digit;
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_above;
  logic [1:7]            seg_raw;
  logic [1:7]            leds_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign tick     = (presc_reg == PRESC_W'(SCAN_DIV - 1));
  assign boundary = tick && (idx_reg == IDX_W'(NUM_DIGITS - 1));

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit[gi] = shadow_reg[gi*BCD_W +: BCD_W];
    end
  endgenerate

  // Walk down from the most significant digit; a digit is a leading zero
  // while it and everything above it is zero. Digit 0 always stays lit.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (digit[i] == '0);
      blank[i]   = (BLANK_LZ != 0) && (i != 0) && zero_above;
    end
  end

  assign cur_digit = digit[idx_reg];

  seg7 u_seg7 (
    .bcd  (cur_digit),
    .leds (seg_raw)
  );

  // First cycle of every slot is dark to avoid ghosting between digits.
  always_comb begin
    leds_next = SEG_BLANK;
    an_next   = '0;
    if (presc_reg != '0) begin
      an_next = NUM_DIGITS'(onehot(32'(idx_reg)));
      if (blank[idx_reg])
        leds_next = SEG_BLANK;
      else if (cur_digit > BCD_W'(9))
        leds_next = SEG_DASH;
      else
        leds_next = seg_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg     <= '0;
      idx_reg       <= '0;
      shadow_reg    <= '0;
      pend_data_reg <= '0;
      pend_reg      <= 1'b0;
      leds          <= SEG_BLANK;
      an            <= '0;
      frame_done    <= 1'b0;
      load_ack      <= 1'b0;
    end else begin
      if (tick) begin
        presc_reg <= '0;
        idx_reg   <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
      end else begin
        presc_reg <= presc_reg + PRESC_W'(1);
      end

      // A load on the boundary cycle is newer than anything pending, so it wins.
      load_ack <= 1'b0;
      if (boundary) begin
        if (load) begin
          shadow_reg <= digits_in;
          load_ack   <= 1'b1;
        end else if (pend_reg) begin
          shadow_reg <= pend_data_reg;
          load_ack   <= 1'b1;
        end
        pend_reg <= 1'b0;
      end else if (load) begin
        pend_data_reg <= digits_in;
        pend_reg      <= 1'b1;
      end

      frame_done <= boundary;
      leds       <= leds_next;
      an         <= an_next;
    end
  end

endmodule
